calc_issue_stage: RTL and testbench

- Upstream issue stage for the combinational 32-bit calculator.
- Accepts commands (operand1, operand2, operator) over a valid/ready handshake and buffers them in a small FIFO.
- Presents the FIFO head to the calculator and registers the calculator's result/overflow into an output stage with valid/ready backpressure.
- Sits between the command source (decoder/host bus) and the result consumer; the calculator instance lives outside this block.

---
 rtl/calc_pkg.sv | 19 +
 rtl/calc_cmd_fifo.sv | 58 +++++
 rtl/calc_issue_stage.sv | 104 ++++++++++
 tb/tb_calc_issue_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator issue stage.
package calc_pkg;

  localparam int CALC_DATA_W = 32;

  typedef enum logic [1:0] {
    CALC_ADD = 2'd0,
    CALC_SUB = 2'd1,
    CALC_MUL = 2'd2,
    CALC_DIV = 2'd3
  } calc_op_e;

  typedef struct packed {
    logic [CALC_DATA_W-1:0] operand1;
    logic [CALC_DATA_W-1:0] operand2;
    calc_op_e               op;
  } calc_cmd_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Command FIFO for the issue stage; head is read combinationally from the read pointer.
module calc_cmd_fifo
  import calc_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type elem_t = calc_cmd_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  elem_t wr_data,
  input  logic  pop,
  output elem_t head,
  output logic  full,
  output logic  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  elem_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/calc_issue_stage.sv
// Issue stage: buffers commands, feeds the external calculator, registers its result.
// Optional statistics counters are enabled with `define CALC_ISSUE_STATS_EN.
module calc_issue_stage
  import calc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = CALC_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_operand1,
  input  logic [DATA_W-1:0] in_operand2,
  input  logic [1:0]        in_operator,
  output logic [DATA_W-1:0] calc_operand1,
  output logic [DATA_W-1:0] calc_operand2,
  output logic [1:0]        calc_operator,
  input  logic [DATA_W-1:0] calc_result,
  input  logic              calc_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_overflow,
  output logic [1:0]        out_op,
  output logic              busy
`ifdef CALC_ISSUE_STATS_EN
  ,
  input  logic              stat_clear,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_divzero
`endif
);

  calc_cmd_t wr_cmd;
  calc_cmd_t head;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  logic      masked_ovf;

  assign wr_cmd = '{operand1: in_operand1, operand2: in_operand2, op: calc_op_e'(in_operator)};

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!out_valid || out_ready);

  calc_cmd_fifo #(
    .DEPTH  (DEPTH),
    .elem_t (calc_cmd_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (wr_cmd),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  assign calc_operand1 = empty ? '0 : head.operand1;
  assign calc_operand2 = empty ? '0 : head.operand2;
  assign calc_operator = empty ? 2'b00 : head.op;

  // The calculator only defines its overflow flag for division.
  assign masked_ovf = (head.op == CALC_DIV) && calc_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_overflow <= 1'b0;
      out_op       <= 2'b00;
    end else if (pop) begin
      out_valid    <= 1'b1;
      out_result   <= calc_result;
      out_overflow <= masked_ovf;
      out_op       <= head.op;
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  assign busy = !empty || out_valid;

`ifdef CALC_ISSUE_STATS_EN
  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued  <= '0;
      stat_divzero <= '0;
    end else if (stat_clear) begin
      stat_issued  <= '0;
      stat_divzero <= '0;
    end else if (pop) begin
      stat_issued  <= stat_issued + 32'd1;
      if (masked_ovf) stat_divzero <= stat_divzero + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_calc_issue_stage.sv
// Self-checking bench for calc_issue_stage: queue-based model plus directed literal checks.
// Define CALC_ISSUE_STATS_EN to also exercise the statistics counters.
module tb_calc_issue_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_operand1 = '0;
  logic [31:0] in_operand2 = '0;
  logic [1:0]  in_operator = '0;
  logic [31:0] calc_operand1;
  logic [31:0] calc_operand2;
  logic [1:0]  calc_operator;
  logic [31:0] calc_result;
  logic        calc_overflow;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_overflow;
  logic [1:0]  out_op;
  logic        busy;
  logic        force_ovf = 1'b0;
`ifdef CALC_ISSUE_STATS_EN
  logic        stat_clear = 1'b0;
  logic [31:0] stat_issued;
  logic [31:0] stat_divzero;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  calc_issue_stage #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_operand1   (in_operand1),
    .in_operand2   (in_operand2),
    .in_operator   (in_operator),
    .calc_operand1 (calc_operand1),
    .calc_operand2 (calc_operand2),
    .calc_operator (calc_operator),
    .calc_result   (calc_result),
    .calc_overflow (calc_overflow),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_op        (out_op),
    .busy          (busy)
`ifdef CALC_ISSUE_STATS_EN
    ,
    .stat_clear    (stat_clear),
    .stat_issued   (stat_issued),
    .stat_divzero  (stat_divzero)
`endif
  );

  // Stand-in calculator; force_ovf lets overflow go high for non-divide ops.
  always_comb begin
    calc_result   = '0;
    calc_overflow = force_ovf;
    case (calc_operator)
      2'd0: calc_result = calc_operand1 + calc_operand2;
      2'd1: calc_result = calc_operand1 - calc_operand2;
      2'd2: calc_result = calc_operand1 * calc_operand2;
      default: begin
        if (calc_operand2 == 32'd0) begin
          calc_result   = '0;
          calc_overflow = 1'b1;
        end else begin
          calc_result   = calc_operand1 / calc_operand2;
          calc_overflow = 1'b0;
        end
      end
    endcase
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] res;
    logic        ovf;
  } ent_t;

  function automatic logic [31:0] exp_res(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      default: return (b == 0) ? 32'd0 : a / b;
    endcase
  endfunction

  // Model: queue of waiting commands plus one output slot.
  ent_t        fq[$];
  ent_t        e;
  bit          m_ov = 0;
  logic [31:0] m_res = '0;
  logic        m_ovf = 0;
  logic [1:0]  m_op = '0;
  int unsigned m_iss = 0;
  int unsigned m_dz = 0;
  bit          m_can_push;
  bit          m_do_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      m_ov = 0; m_res = '0; m_ovf = 0; m_op = '0; m_iss = 0; m_dz = 0;
    end else begin
      m_can_push = fq.size() < DEPTH;
      m_do_pop   = (fq.size() > 0) && (!m_ov || out_ready);
`ifdef CALC_ISSUE_STATS_EN
      if (stat_clear) begin
        m_iss = 0; m_dz = 0;
      end else if (m_do_pop) begin
        m_iss++;
        if (fq[0].ovf) m_dz++;
      end
`endif
      if (m_do_pop) begin
        e = fq.pop_front();
        m_ov = 1; m_res = e.res; m_ovf = e.ovf; m_op = e.op;
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
      if (in_valid && m_can_push) begin
        e.a = in_operand1; e.b = in_operand2; e.op = in_operator;
        e.res = exp_res(in_operator, in_operand1, in_operand2);
        e.ovf = (in_operator == 2'd3) && (in_operand2 == 32'd0);
        fq.push_back(e);
      end
    end
  end

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      checkOutput("in_ready", in_ready, fq.size() < DEPTH);
      checkOutput("out_valid", out_valid, m_ov);
      checkOutput("busy", busy, (fq.size() > 0) || m_ov);
      checkOutput("calc_operand1", calc_operand1, fq.size() > 0 ? fq[0].a : 32'd0);
      checkOutput("calc_operand2", calc_operand2, fq.size() > 0 ? fq[0].b : 32'd0);
      checkOutput("calc_operator", calc_operator, fq.size() > 0 ? fq[0].op : 2'd0);
      if (m_ov) begin
        checkOutput("out_result", out_result, m_res);
        checkOutput("out_overflow", out_overflow, m_ovf);
        checkOutput("out_op", out_op, m_op);
      end
`ifdef CALC_ISSUE_STATS_EN
      checkOutput("stat_issued", stat_issued, m_iss);
      checkOutput("stat_divzero", stat_divzero, m_dz);
`endif
    end
  end

  // Called just after a rising edge; returns just after the accepting edge with in_valid still high.
  task automatic applyStimulus(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    bit r;
    bit acc = 0;
    in_valid = 1'b1; in_operator = op; in_operand1 = a; in_operand2 = b;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); acc = r;
    end
    if (!acc) checkOutput("push_timeout", acc, 1);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_beat(string name, logic [31:0] res, logic ovf, logic [1:0] op);
    bit found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) found = 1;
    end
    checkOutput({name, "_valid"}, found, 1);
    if (found) begin
      checkOutput({name, "_result"}, out_result, res);
      checkOutput({name, "_ovf"}, out_overflow, ovf);
      checkOutput({name, "_op"}, out_op, op);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beats;
    int start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    #2;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_result", out_result, 0);
    checkOutput("rst_out_overflow", out_overflow, 0);
    checkOutput("rst_out_op", out_op, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_calc_operand1", calc_operand1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;
    cycles(1);

    $display("[TB] latency: 7+5");
    applyStimulus(2'd0, 32'd7, 32'd5);
    idle();
    checkOutput("lat_edge_n_valid", out_valid, 0);
    cycles(1);
    checkOutput("lat_edge_n1_valid", out_valid, 1);
    checkOutput("lat_result", out_result, 32'd12);
    checkOutput("lat_ovf", out_overflow, 0);
    checkOutput("lat_op", out_op, 0);
    cycles(2);

    $display("[TB] divide and overflow masking");
    applyStimulus(2'd3, 32'd10, 32'd0); idle();
    wait_beat("div0", 32'd0, 1'b1, 2'd3);
    cycles(1);
    applyStimulus(2'd3, 32'd9, 32'd3); idle();
    wait_beat("div9_3", 32'd3, 1'b0, 2'd3);
    cycles(1);
    force_ovf = 1'b1;
    applyStimulus(2'd1, 32'd3, 32'd5); idle();
    wait_beat("sub_mask", 32'hFFFF_FFFE, 1'b0, 2'd1);
    cycles(1);
    force_ovf = 1'b0;
    applyStimulus(2'd2, 32'h0001_0000, 32'h0001_0000); idle();
    wait_beat("mul_wrap", 32'd0, 1'b0, 2'd2);
    cycles(1);

    $display("[TB] backpressure fill");
    out_ready = 1'b0;
    applyStimulus(2'd0, 32'd1, 32'd1);
    applyStimulus(2'd1, 32'd8, 32'd2);
    applyStimulus(2'd2, 32'd6, 32'd7);
    applyStimulus(2'd3, 32'd20, 32'd4);
    applyStimulus(2'd0, 32'hFFFF_FFFF, 32'd1);
    idle();
    @(negedge clk);
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_out_valid", out_valid, 1);
    checkOutput("full_head_result", out_result, 32'd2);
    checkOutput("full_busy", busy, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_beat("drain1", 32'd2, 1'b0, 2'd0);
    wait_beat("drain2", 32'd6, 1'b0, 2'd1);
    wait_beat("drain3", 32'd42, 1'b0, 2'd2);
    wait_beat("drain4", 32'd5, 1'b0, 2'd3);
    wait_beat("drain5", 32'd0, 1'b0, 2'd0);
    @(negedge clk);
    checkOutput("drain_no_dup", out_valid, 0);
    cycles(1);

    $display("[TB] streaming 100 commands");
    start = cyc;
    for (int i = 0; i < 100; i++) begin
      if (i == 0) begin
        op = 2'd2; a = 32'h0001_0000; b = 32'h0001_0000;
      end else begin
        op = 2'($urandom_range(0, 3));
        a = $urandom;
        b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      end
      applyStimulus(op, a, b);
    end
    idle();
    checkOutput("stream_cycles", cyc - start, 100);
    cycles(4);

    $display("[TB] reset mid-operation");
    out_ready = 1'b0;
    applyStimulus(2'd0, 32'd100, 32'd1);
    applyStimulus(2'd0, 32'd200, 32'd2);
    applyStimulus(2'd0, 32'd300, 32'd3);
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_in_ready", in_ready, 1);
    checkOutput("mid_rst_result", out_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    beats = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid === 1'b1) beats++;
    end
    checkOutput("post_rst_no_stale", beats, 0);
    checkOutput("post_rst_in_ready", in_ready, 1);
    cycles(1);

`ifdef CALC_ISSUE_STATS_EN
    $display("[TB] statistics counters");
    stat_clear = 1'b1;
    cycles(1);
    stat_clear = 1'b0;
    applyStimulus(2'd0, 32'd1, 32'd2);
    applyStimulus(2'd3, 32'd10, 32'd0);
    applyStimulus(2'd1, 32'd5, 32'd3);
    applyStimulus(2'd2, 32'd4, 32'd4);
    applyStimulus(2'd3, 32'd7, 32'd0);
    applyStimulus(2'd3, 32'd8, 32'd2);
    idle();
    cycles(4);
    checkOutput("stat_issued_6", stat_issued, 32'd6);
    checkOutput("stat_divzero_2", stat_divzero, 32'd2);
    applyStimulus(2'd3, 32'd1, 32'd0);
    idle();
    stat_clear = 1'b1;
    cycles(1);
    stat_clear = 1'b0;
    checkOutput("stat_clear_issued", stat_issued, 32'd0);
    checkOutput("stat_clear_divzero", stat_divzero, 32'd0);
    cycles(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
